// File: rtl/pa_resp_pkg.sv
// -----------------------------------------------------------------------------
// pa_resp_pkg
// Shared types for the page-walk response queue.
//   PA_W          physical address width
//   pa_resp_t     one queued response: {pa, fault}
//   occ_state_e   queue occupancy class (EMPTY / PARTIAL / FULL)
//   occ_state_of  maps an entry count onto occ_state_e
// -----------------------------------------------------------------------------
package pa_resp_pkg;

    localparam int PA_W = 28;

    typedef struct packed {
        logic [PA_W-1:0] pa;
        logic            fault;
    } pa_resp_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

    function automatic occ_state_e occ_state_of(input int occ, input int depth);
        if (occ == 0)
            return OCC_EMPTY;
        if (occ >= depth)
            return OCC_FULL;
        return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/pa_resp_ram.sv
// -----------------------------------------------------------------------------
// pa_resp_ram
// DEPTH x pa_resp_t storage, one synchronous write port, one asynchronous
// read port.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module pa_resp_ram
    import pa_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  pa_resp_t                   wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output pa_resp_t                   rdata_o
);

    pa_resp_t mem [DEPTH];

    // NOTE: non-blocking for all clocked state; the array has no reset because
    // occupancy, not contents, decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pa_resp_q.sv
// -----------------------------------------------------------------------------
// pa_resp_q
// FIFO between the page-walk unit and its consumer. Every accepted PA is
// queued with its fault flag (faulted entries are kept in order). Accepted
// faults are counted (saturating) and the PA of the first fault since the
// last clear is captured.
//
// Optional feature: define PA_RESP_BYPASS_EN to let an input flow straight to
// resp_* in the same cycle when the queue is empty and the consumer is ready.
// Without it, resp_* is driven purely from registered state.
//
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   pa_i/pa_vld_i/pa_fault_i   producer side, pa_rdy_o back-pressure
//   resp_pa_o/resp_fault_o/resp_vld_o  consumer side, resp_rdy_i
//   occ_o              current entry count
//   fault_cnt_o        saturating count of accepted faults
//   first_fault_pa_o/first_fault_vld_o  first-fault capture
//   fault_clr_i        clears counter and capture
// -----------------------------------------------------------------------------
module pa_resp_q
    import pa_resp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PA_W-1:0]          pa_i,
    input  logic                     pa_vld_i,
    input  logic                     pa_fault_i,
    output logic                     pa_rdy_o,
    output logic [PA_W-1:0]          resp_pa_o,
    output logic                     resp_fault_o,
    output logic                     resp_vld_o,
    input  logic                     resp_rdy_i,
    output logic [$clog2(DEPTH):0]   occ_o,
    output logic [CNT_W-1:0]         fault_cnt_o,
    output logic [PA_W-1:0]          first_fault_pa_o,
    output logic                     first_fault_vld_o,
    input  logic                     fault_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [AW:0]      OCC_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    occ_state_e    occ_state;

    logic     accept;
    logic     push_q;
    logic     pop_q;
    logic     fault_push;
    pa_resp_t wdata;
    pa_resp_t rdata;
    pa_resp_t resp;

    assign occ_state = occ_state_of(int'(occ), DEPTH);

    // Full blocks a push even when a pop happens in the same cycle.
    assign pa_rdy_o   = (occ_state != OCC_FULL);
    assign accept     = pa_vld_i && pa_rdy_o;
    assign fault_push = accept && pa_fault_i;
    assign pop_q      = (occ_state != OCC_EMPTY) && resp_rdy_i;
    assign wdata      = '{pa: pa_i, fault: pa_fault_i};

`ifdef PA_RESP_BYPASS_EN
    logic bypass;

    // An input consumed in the same cycle it arrives never enters storage.
    assign bypass     = (occ_state == OCC_EMPTY) && pa_vld_i && resp_rdy_i;
    assign push_q     = accept && !bypass;
    assign resp_vld_o = (occ_state != OCC_EMPTY) || pa_vld_i;

    // NOTE: default first so every path assigns resp and no latch is inferred.
    always_comb begin
        resp = rdata;
        if (occ_state == OCC_EMPTY)
            resp = wdata;
    end
`else
    assign push_q     = accept;
    assign resp_vld_o = (occ_state != OCC_EMPTY);

    always_comb begin
        resp = rdata;
    end
`endif

    assign resp_pa_o    = resp.pa;
    assign resp_fault_o = resp.fault;
    assign occ_o        = occ;

    pa_resp_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_q),
        .waddr_i (wr_ptr),
        .wdata_i (wdata),
        .raddr_i (rd_ptr),
        .rdata_o (rdata)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_q)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_q)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_q, pop_q})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // A faulted push coinciding with a clear is recorded as the first fault
    // of the new window rather than being lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_cnt_o       <= '0;
            first_fault_pa_o  <= '0;
            first_fault_vld_o <= 1'b0;
        end else if (fault_clr_i) begin
            fault_cnt_o       <= fault_push ? CNT_ONE : '0;
            first_fault_pa_o  <= fault_push ? pa_i : '0;
            first_fault_vld_o <= fault_push;
        end else if (fault_push) begin
            if (fault_cnt_o != CNT_MAX)
                fault_cnt_o <= fault_cnt_o + CNT_ONE;
            if (!first_fault_vld_o) begin
                first_fault_pa_o  <= pa_i;
                first_fault_vld_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pa_resp_q.sv
// -----------------------------------------------------------------------------
// tb_pa_resp_q
// Drives two instances of pa_resp_q (default counter width and a 4-bit
// counter) with identical stimulus and compares them against a queue-based
// reference model: entries are a plain FIFO, faults a raw count clipped to
// the counter maximum, plus a first-fault capture.
// -----------------------------------------------------------------------------
module tb_pa_resp_q;

    localparam int DEPTH = 4;
    localparam int PA_W  = 28;

    typedef struct {
        logic [PA_W-1:0] pa;
        logic            fault;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [PA_W-1:0] pa = '0;
    logic pa_vld = 1'b0;
    logic pa_fault = 1'b0;
    logic resp_rdy = 1'b0;
    logic fault_clr = 1'b0;

    logic            pa_rdy, resp_fault, resp_vld, ff_vld_o;
    logic [PA_W-1:0] resp_pa, ff_pa_o;
    logic [2:0]      occ;
    logic [15:0]     fcnt;

    logic            pa_rdy_c4, resp_fault_c4, resp_vld_c4, ff_vld_c4;
    logic [PA_W-1:0] resp_pa_c4, ff_pa_c4;
    logic [2:0]      occ_c4;
    logic [3:0]      fcnt_c4;

    int checks = 0;
    int errors = 0;

    ent_t            q[$];
    int unsigned     raw_faults = 0;
    logic            m_ff_vld = 1'b0;
    logic [PA_W-1:0] m_ff_pa = '0;

    always #5 clk = ~clk;

    pa_resp_q #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .pa_i(pa), .pa_vld_i(pa_vld), .pa_fault_i(pa_fault),
        .pa_rdy_o(pa_rdy), .resp_pa_o(resp_pa), .resp_fault_o(resp_fault),
        .resp_vld_o(resp_vld), .resp_rdy_i(resp_rdy), .occ_o(occ), .fault_cnt_o(fcnt),
        .first_fault_pa_o(ff_pa_o), .first_fault_vld_o(ff_vld_o), .fault_clr_i(fault_clr)
    );

    pa_resp_q #(.DEPTH(DEPTH), .CNT_W(4)) dut_c4 (
        .clk_i(clk), .rst_i(rst), .pa_i(pa), .pa_vld_i(pa_vld), .pa_fault_i(pa_fault),
        .pa_rdy_o(pa_rdy_c4), .resp_pa_o(resp_pa_c4), .resp_fault_o(resp_fault_c4),
        .resp_vld_o(resp_vld_c4), .resp_rdy_i(resp_rdy), .occ_o(occ_c4), .fault_cnt_o(fcnt_c4),
        .first_fault_pa_o(ff_pa_c4), .first_fault_vld_o(ff_vld_c4), .fault_clr_i(fault_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] clip(input int unsigned n, input int unsigned max);
        return (n > max) ? max : n;
    endfunction

    // One clock of stimulus: drive, compare settled outputs with the model,
    // then advance the model across the rising edge.
    task automatic step(input logic v, input logic [PA_W-1:0] a, input logic f,
                        input logic r, input logic c);
        logic            exp_vld, bypass, accept, pop, fault_acc;
        logic [PA_W-1:0] exp_pa;
        logic            exp_f;
        pa_vld = v; pa = a; pa_fault = f; resp_rdy = r; fault_clr = c;
        #3;
        accept = v && (q.size() < DEPTH);
`ifdef PA_RESP_BYPASS_EN
        exp_vld = (q.size() != 0) || v;
        bypass  = (q.size() == 0) && v && r;
`else
        exp_vld = (q.size() != 0);
        bypass  = 1'b0;
`endif
        if (q.size() != 0) begin
            exp_pa = q[0].pa;
            exp_f  = q[0].fault;
        end else begin
            exp_pa = a;
            exp_f  = f;
        end
        check("pa_rdy", pa_rdy, q.size() < DEPTH);
        check("occ", occ, q.size());
        check("occ_c4", occ_c4, q.size());
        check("resp_vld", resp_vld, exp_vld);
        if (exp_vld) begin
            check("resp_pa", resp_pa, exp_pa);
            check("resp_fault", resp_fault, exp_f);
        end
        check("fault_cnt", fcnt, clip(raw_faults, 16'hFFFF));
        check("fault_cnt_c4", fcnt_c4, clip(raw_faults, 4'hF));
        check("ff_vld", ff_vld_o, m_ff_vld);
        if (m_ff_vld)
            check("ff_pa", ff_pa_o, m_ff_pa);

        pop       = (q.size() != 0) && r;
        fault_acc = accept && f;
        @(posedge clk);
        #1;
        if (pop)
            void'(q.pop_front());
        if (accept && !bypass)
            q.push_back('{pa: a, fault: f});
        if (c) begin
            raw_faults = fault_acc ? 1 : 0;
            m_ff_vld   = fault_acc;
            m_ff_pa    = fault_acc ? a : '0;
        end else if (fault_acc) begin
            raw_faults++;
            if (!m_ff_vld) begin
                m_ff_vld = 1'b1;
                m_ff_pa  = a;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pa_vld = 1'b0; pa_fault = 1'b0; resp_rdy = 1'b0; fault_clr = 1'b0; pa = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        raw_faults = 0; m_ff_vld = 1'b0; m_ff_pa = '0;
        #3;
        check("rst_occ", occ, 0);
        check("rst_resp_vld", resp_vld, 0);
        check("rst_pa_rdy", pa_rdy, 1);
        check("rst_fault_cnt", fcnt, 0);
        check("rst_ff_vld", ff_vld_o, 0);
        check("rst_ff_pa", ff_pa_o, 0);
    endtask

    initial begin
        do_reset();

        // Single push appears one cycle later.
        step(1'b1, 28'h0000123, 1'b0, 1'b0, 1'b0);
        pa_vld = 1'b0; #1;
        check("first_vld", resp_vld, 1);
        check("first_pa", resp_pa, 28'h0000123);
        check("first_occ", occ, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Fill to full with the consumer stalled; fifth entry held by source.
        for (int i = 0; i < 5; i++)
            step(1'b1, 28'h100 + 28'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 28'h104, 1'b0, 1'b0, 1'b0);
        pa_vld = 1'b0; #1;
        check("full_pa_rdy", pa_rdy, 0);
        check("full_occ", occ, 4);
        for (int i = 0; i < 4; i++) begin
            resp_rdy = 1'b1; #1;
            check("drain_order", resp_pa, 28'h100 + 28'(i));
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("drained_occ", occ, 0);

        // Steady push+pop at occ=2 across pointer wrap.
        step(1'b1, 28'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 28'h201, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 28'h202 + 28'(i), 1'b0, 1'b1, 1'b0);
        pa_vld = 1'b0; #1;
        check("wrap_occ", occ, 2);
        check("wrap_head", resp_pa, 28'h20A);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("wrap_next", resp_pa, 28'h20B);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Fault counting, first capture, clear with coincident faulted push.
        step(1'b1, 28'h00000AA, 1'b1, 1'b1, 1'b0);
        step(1'b1, 28'h00000BB, 1'b1, 1'b1, 1'b0);
        pa_vld = 1'b0; #1;
        check("fault_cnt_2", fcnt, 2);
        check("ff_pa_AA", ff_pa_o, 28'h00000AA);
        step(1'b1, 28'h00000CC, 1'b1, 1'b1, 1'b1);
        pa_vld = 1'b0; fault_clr = 1'b0; #1;
        check("clr_cnt_1", fcnt, 1);
        check("clr_ff_pa_CC", ff_pa_o, 28'h00000CC);
        check("clr_ff_vld", ff_vld_o, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Saturation of the narrow counter.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b1, 28'h300 + 28'(i), 1'b1, 1'b1, 1'b0);
        pa_vld = 1'b0; #1;
        check("sat_c4", fcnt_c4, 4'hF);
        check("sat_c16", fcnt, 20);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

`ifdef PA_RESP_BYPASS_EN
        pa_vld = 1'b1; pa = 28'h0ABCDEF; pa_fault = 1'b0; resp_rdy = 1'b1; #1;
        check("byp_vld", resp_vld, 1);
        check("byp_pa", resp_pa, 28'h0ABCDEF);
        check("byp_occ", occ, 0);
        step(1'b1, 28'h0ABCDEF, 1'b0, 1'b1, 1'b0);
        pa_vld = 1'b0; #1;
        check("byp_occ_after", occ, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 28'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

        // Reset with entries in flight discards them.
        for (int i = 0; i < 3; i++)
            step(1'b1, 28'h400 + 28'(i), 1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
